frame_builder: RTL and testbench
================================

// Module: frame_builder
// PURPOSE
//  Transmit-side counterpart of the frame parser. Latches an N_BYTES payload on
//  start and emits one complete frame, byte by byte, to the UART transmitter
//  over a valid/ready byte handshake. Frame layout:
//  HDR, LEN, CMD, D[0..N_BYTES-1], CHK, TAIL.
//  CHK makes the 8-bit sum of all frame bytes, TAIL included, equal 0xFF.
// PARAMETERS
//  N_BYTES   8      payload bytes per frame; LEN byte = N_BYTES+5 (8 -> 0x0D)
//  HDR_BYTE  8'h52  header byte
//  CMD_BYTE  8'h01  command byte
//  TAIL_BYTE 8'h9A  tail byte
// PORTS
//  clk       in   1            clock; all logic on posedge
//  rst_n     in   1            reset, synchronous, active-low
//  start     in   1            request to send payload; sampled only in IDLE
//  payload   in   8*N_BYTES    frame data; D[0] = payload[8*N_BYTES-1 -: 8] (MSB byte first)
//  tx_data   out  8            byte to UART TX
//  tx_valid  out  1            tx_data holds a frame byte
//  tx_ready  in   1            UART TX accepts tx_data this cycle
//  busy      out  1            frame in progress
//  done      out  1            one-cycle pulse after TAIL byte is accepted
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; tx_data=0, tx_valid=0, busy=0, done=0;
//   payload/checksum regs cleared. Reset mid-frame aborts the frame at once:
//   tx_valid drops the next cycle, with no done pulse.
//  All outputs are registered.
//  States: IDLE, HDR, LEN, CMD, DATA, CHK, TAIL, DONE.
//  IDLE: start=1 at posedge N -> latch payload; clear byte counter;
//   preload sum = HDR+LEN+CMD+TAIL (mod 256).
//   At N+1: state=HDR, busy=1, tx_valid=1, tx_data=HDR_BYTE.
//  Byte transfer: a byte transfers on a posedge with tx_valid & tx_ready.
//   - While tx_valid=1 & tx_ready=0, tx_data and state hold unchanged.
//   - tx_valid never drops mid-frame.
//   - Each transfer advances to the next byte on the following cycle.
//  HDR -> LEN (N_BYTES+5) -> CMD -> DATA.
//  DATA: emit D[cnt], sum += D[cnt], cnt++. After D[N_BYTES-1] transfers -> CHK.
//  CHK: tx_data = 8'hFF - sum (mod 256), where sum covers HDR, LEN, CMD, all D
//   and TAIL. With defaults: CHK = 8'h05 - sum(D) (mod 256).
//  TAIL: emit TAIL_BYTE. On transfer -> DONE.
//  DONE (one cycle): tx_valid=0, busy=0, done=1; next cycle -> IDLE.
//  start while not in IDLE (including the DONE cycle) is ignored; no queuing.
//   The payload input may change freely after the start cycle.
//  Latency with tx_ready held at 1: start at cycle N -> bytes on N+1..N+N_BYTES+5,
//   done at N+N_BYTES+6. Minimum start-to-start spacing is N_BYTES+7 cycles.
//  Arithmetic: 8-bit wrap-around sum. Counter width is clog2(N_BYTES)+1.
//   With tx_ready tied high, the frame completes with no stalls.
// TESTING
//  1. payload=0, tx_ready=1 -> bytes 52 0D 01 00x8 05 9A, done at start+14.
//  2. payload=64'h0102030405060708 -> data bytes 01..08 in order, CHK=E1,
//     TAIL=9A; sum of the 13 bytes mod 256 = FF.
//  3. payload=all FF -> CHK=0D. Loop the output back into the parser:
//     the parser accepts the frame and outputs FFFFFFFFFFFFFFFF.
//  4. tx_ready toggled randomly (~50%) -> byte sequence identical to case 2;
//     tx_data never changes while tx_valid & !tx_ready.
//  5. start pulsed during DATA and during DONE -> ignored: exactly one frame,
//     no second busy.
//  6. rst_n=0 during the CHK byte -> next cycle tx_valid=0, busy=0, done=0;
//     a new start afterwards yields a full, correct frame.

Source files
------------

// File: rtl/frame_builder.sv
// Transmit-side frame builder: latches a payload on start and emits
// HDR, LEN, CMD, D[0..N-1], CHK, TAIL over a valid/ready byte handshake.
module frame_builder #(
  parameter int         N_BYTES   = 8,
  parameter logic [7:0] HDR_BYTE  = 8'h52,
  parameter logic [7:0] CMD_BYTE  = 8'h01,
  parameter logic [7:0] TAIL_BYTE = 8'h9A
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8*N_BYTES-1:0]   payload,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int         PW       = 8 * N_BYTES;
  localparam int         CNT_W    = $clog2(N_BYTES) + 1;
  localparam logic [7:0] LEN_BYTE = 8'(N_BYTES + 5);
  localparam logic [7:0] SUM_INIT = HDR_BYTE + LEN_BYTE + CMD_BYTE + TAIL_BYTE;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LEN  = 3'd2,
    S_CMD  = 3'd3,
    S_DATA = 3'd4,
    S_CHK  = 3'd5,
    S_TAIL = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t           state_r;
  logic [PW-1:0]    payload_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       sum_r;
  logic [7:0]       sum_add_s;
  logic             xfer_s;

  // Checksum byte that brings the 8-bit sum of the whole frame to 0xFF.
  function automatic logic [7:0] chk_byte(input logic [7:0] sum);
    return 8'hFF - sum;
  endfunction

  assign xfer_s    = tx_valid & tx_ready;
  assign sum_add_s = sum_r + tx_data;

  // Frame sequencer; every output is driven from here so all are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      payload_r <= '0;
      cnt_r     <= '0;
      sum_r     <= 8'h00;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            payload_r <= payload;
            cnt_r     <= '0;
            sum_r     <= SUM_INIT;
            state_r   <= S_HDR;
            busy      <= 1'b1;
            tx_valid  <= 1'b1;
            tx_data   <= HDR_BYTE;
          end
        end
        S_HDR: begin
          if (xfer_s) begin
            state_r <= S_LEN;
            tx_data <= LEN_BYTE;
          end
        end
        S_LEN: begin
          if (xfer_s) begin
            state_r <= S_CMD;
            tx_data <= CMD_BYTE;
          end
        end
        S_CMD: begin
          if (xfer_s) begin
            state_r <= S_DATA;
            tx_data <= payload_r[PW-1 -: 8];
          end
        end
        // The byte on the bus is always the top of payload_r; shift on transfer.
        S_DATA: begin
          if (xfer_s) begin
            sum_r <= sum_add_s;
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_CNT) begin
              state_r <= S_CHK;
              tx_data <= chk_byte(sum_add_s);
            end else begin
              payload_r <= {payload_r[PW-9:0], 8'h00};
              tx_data   <= payload_r[PW-9 -: 8];
            end
          end
        end
        S_CHK: begin
          if (xfer_s) begin
            state_r <= S_TAIL;
            tx_data <= TAIL_BYTE;
          end
        end
        S_TAIL: begin
          if (xfer_s) begin
            state_r  <= S_DONE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r  <= S_IDLE;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          tx_data  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_builder.sv
// Scoreboard bench for frame_builder: stimulus pushes model-built frames,
// an independent monitor pops and compares every transferred byte.
module tb_frame_builder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] payload;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  int          vectors;
  int          miscompares;
  logic [7:0]  exp_q[$];
  int          byte_cnt;
  bit          ready_rand;
  bit          prev_stall;
  logic [7:0]  prev_data;

  frame_builder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .payload  (payload),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference frame: fixed bytes around the payload, CHK chosen so all bytes sum to 0xFF.
  task automatic push_expected(input logic [63:0] pl);
    logic [7:0] sum;
    logic [7:0] d;
    sum = 8'h52 + 8'h0D + 8'h01 + 8'h9A;
    exp_q.push_back(8'h52);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h01);
    for (int i = 0; i < 8; i++) begin
      d = pl[63 - 8*i -: 8];
      exp_q.push_back(d);
      sum = sum + d;
    end
    exp_q.push_back(8'hFF - sum);
    exp_q.push_back(8'h9A);
  endtask

  // mode 0: plain frame, 1: stray start pulses in DATA and DONE, 2: reset during CHK
  task automatic run_frame(input logic [63:0] pl, input bit rnd, input int mode);
    int cnt;
    ready_rand = rnd;
    @(posedge clk) #1;
    start   = 1'b1;
    payload = pl;
    push_expected(pl);
    @(posedge clk) #1;
    start   = 1'b0;
    payload = {$urandom, $urandom};
    if (mode == 2) begin
      repeat (11) @(posedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_mid_valid", tx_valid, 1'b0);
      check("rst_mid_busy", busy, 1'b0);
      check("rst_mid_done", done, 1'b0);
      @(posedge clk) #1 rst_n = 1'b1;
    end else begin
      cnt = 0;
      while (1) begin
        @(negedge clk);
        cnt++;
        if (mode == 1 && cnt == 6) start = 1'b1;
        if (mode == 1 && cnt == 7) start = 1'b0;
        if (done) break;
        if (cnt > 300) break;
      end
      check("done_seen", done, 1'b1);
      if (!rnd) check("done_latency", cnt, 14);
      if (mode == 1) begin
        start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        repeat (20) @(negedge clk);
        check("no_second_busy", busy, 1'b0);
        check("no_second_valid", tx_valid, 1'b0);
      end
    end
  endtask

  // tx_ready driver: held high or toggled randomly, changed just after each edge.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk) #1;
      tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops one expected byte per handshake, checks stall hold and done framing.
  initial begin
    byte_cnt   = 0;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        byte_cnt   = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_hold_data", tx_data, prev_data);
          check("stall_hold_valid", tx_valid, 1'b1);
        end
        if (tx_valid) check("busy_with_valid", busy, 1'b1);
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_byte: got %0h expected no byte", tx_data);
          end else begin
            check("frame_byte", tx_data, exp_q.pop_front());
            byte_cnt++;
          end
        end
        if (done) begin
          check("done_byte_count", byte_cnt, 13);
          check("done_queue_empty", exp_q.size(), 0);
          check("done_valid_low", tx_valid, 1'b0);
          byte_cnt = 0;
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    ready_rand  = 1'b0;
    rst_n       = 1'b0;
    start       = 1'b0;
    payload     = 64'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx_data", tx_data, 8'h00);
    check("reset_tx_valid", tx_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    @(posedge clk) #1 rst_n = 1'b1;

    run_frame(64'h0, 1'b0, 0);
    run_frame(64'h0102030405060708, 1'b0, 0);
    run_frame(64'hFFFFFFFFFFFFFFFF, 1'b0, 0);
    run_frame(64'h0102030405060708, 1'b1, 0);
    run_frame({$urandom, $urandom}, 1'b0, 1);
    run_frame({$urandom, $urandom}, 1'b0, 2);
    run_frame(64'h0102030405060708, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      run_frame({$urandom, $urandom}, 1'($urandom_range(0, 1)), 0);
    end

    repeat (5) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
